// File: rtl/store_byte_merge.sv
// Read-modify-write store unit for sb: reads the aligned word, replaces one byte lane, writes it back.
// Define STORE_BYTE_MERGE_HALF_EN to add halfword stores (ports half and misalign).
module store_byte_merge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
`ifdef STORE_BYTE_MERGE_HALF_EN
    input  logic              half,
    output logic              misalign,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done
);

`ifdef STORE_BYTE_MERGE_HALF_EN
    localparam int DATA_W = 16;
`else
    localparam int DATA_W = 8;
`endif

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       merged;

    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_rd_en_d;
    logic              mem_wr_en_d;
    logic [31:0]       mem_wdata_d;
    logic              busy_d;
    logic              done_d;

    // Only the low lane(s) of rt are ever stored.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:DATA_W];

    assign accept = (state == IDLE) && start;

`ifdef STORE_BYTE_MERGE_HALF_EN
    logic half_q;
    logic misalign_d;
    logic req_misalign;
    assign req_misalign = half && addr[0];
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef STORE_BYTE_MERGE_HALF_EN
                    state_next = req_misalign ? DONE : READ;
`else
                    state_next = READ;
`endif
                end
            end
            READ:    state_next = WAIT;
            WAIT:    if (mem_rd_valid) state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
`ifdef STORE_BYTE_MERGE_HALF_EN
        if (half_q) begin
            if (lane_q[1]) merged[31:16] = data_q;
            else           merged[15:0]  = data_q;
        end else
`endif
        begin
            case (lane_q)
                2'd0: merged[7:0]   = data_q[7:0];
                2'd1: merged[15:8]  = data_q[7:0];
                2'd2: merged[23:16] = data_q[7:0];
                2'd3: merged[31:24] = data_q[7:0];
                default: merged = mem_rdata;
            endcase
        end
    end

    // Outputs are computed from the next state and registered alongside it.
    always_comb begin
        mem_rd_en_d = (state_next == READ);
        mem_wr_en_d = (state_next == WRITE);
        busy_d      = (state_next != IDLE);
        done_d      = (state_next == DONE);
        mem_addr_d  = accept ? {addr[ADDR_W-1:2], 2'b00} : mem_addr;
        mem_wdata_d = (state == WAIT && mem_rd_valid) ? merged : mem_wdata;
`ifdef STORE_BYTE_MERGE_HALF_EN
        misalign_d  = accept && req_misalign;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lane_q    <= '0;
            data_q    <= '0;
`ifdef STORE_BYTE_MERGE_HALF_EN
            half_q    <= 1'b0;
            misalign  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            mem_addr  <= mem_addr_d;
            mem_rd_en <= mem_rd_en_d;
            mem_wr_en <= mem_wr_en_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef STORE_BYTE_MERGE_HALF_EN
            misalign  <= misalign_d;
            if (accept) half_q <= half;
`endif
            if (accept) begin
                lane_q <= addr[1:0];
                data_q <= wdata[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_store_byte_merge.sv
// Self-checking bench for store_byte_merge: cycle-exact timeline checks plus a write scoreboard.
module tb_store_byte_merge;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_rd_valid;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
`ifdef STORE_BYTE_MERGE_HALF_EN
    logic        half;
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    store_byte_merge #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .addr         (addr),
        .wdata        (wdata),
`ifdef STORE_BYTE_MERGE_HALF_EN
        .half         (half),
        .misalign     (misalign),
`endif
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%h, none expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write_data: addr=%h data=%h, want addr=%h data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
        if (mem_rd_en && mem_wr_en) begin
            bad++;
            $display("FAIL strobe_overlap: rd_en=%b wr_en=%b, want not both", mem_rd_en, mem_wr_en);
        end
    end

    function automatic logic [31:0] model_merge(input logic [31:0] rd, input logic [31:0] a,
                                                input logic [31:0] d, input bit h);
        logic [31:0] mask;
        logic [31:0] val;
        if (h) begin
            mask = 32'h0000FFFF << (16 * a[1]);
            val  = {16'h0, d[15:0]} << (16 * a[1]);
        end else begin
            mask = 32'h000000FF << (8 * a[1:0]);
            val  = {24'h0, d[7:0]} << (8 * a[1:0]);
        end
        return (rd & ~mask) | val;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full store with `extra` stall cycles; ends in the IDLE cycle after DONE.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                            input int extra, input bit h, input bit poke_start);
        logic [31:0] al;
        wr_t e;
        al  = {a[31:2], 2'b00};
        e.a = al;
        e.d = model_merge(rd, a, d, h);
        exp_q.push_back(e);
        start = 1'b1; addr = a; wdata = d;
`ifdef STORE_BYTE_MERGE_HALF_EN
        half = h;
`endif
        tick();
        start = 1'b0;
        total++;
        if (mem_rd_en !== 1'b1 || busy !== 1'b1 || mem_addr !== al || done !== 1'b0) begin
            bad++;
            $display("FAIL read_cycle: rd_en=%b busy=%b addr=%h done=%b, want 1 1 %h 0",
                     mem_rd_en, busy, mem_addr, done, al);
        end
        tick();
        for (int i = 0; i < extra + 1; i++) begin
            total++;
            if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || busy !== 1'b1 || mem_addr !== al || done !== 1'b0) begin
                bad++;
                $display("FAIL wait_cycle%0d: rd=%b wr=%b busy=%b addr=%h done=%b, want 0 0 1 %h 0",
                         i, mem_rd_en, mem_wr_en, busy, mem_addr, done, al);
            end
            if (i == extra) begin
                mem_rd_valid = 1'b1; mem_rdata = rd;
            end else if (poke_start && i == 0) begin
                start = 1'b1; addr = 32'h0000_0300; wdata = 32'h77;
            end
            tick();
            start = 1'b0;
            mem_rd_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        end
        total++;
        if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || busy !== 1'b1 || mem_addr !== al) begin
            bad++;
            $display("FAIL write_cycle: wr=%b rd=%b busy=%b addr=%h, want 1 0 1 %h",
                     mem_wr_en, mem_rd_en, busy, mem_addr, al);
        end
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle: done=%b busy=%b wr=%b rd=%b, want 1 1 0 0",
                     done, busy, mem_wr_en, mem_rd_en);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                     name, busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_rd_valid = 1'b0;
`ifdef STORE_BYTE_MERGE_HALF_EN
        half = 1'b0;
`endif
        repeat (2) tick();
        reset = 1'b0;
        check_all_zero("reset_state");
        tick();
        check_all_zero("idle_no_start");
    endtask

    task automatic test_basic();
        do_store(32'h100, 32'h0000_00AB, 32'h1122_3344, 0, 1'b0, 1'b0);
    endtask

    task automatic test_lanes();
        do_store(32'h101, 32'h0000_00CD, 32'h1122_3344, 0, 1'b0, 1'b0);
        do_store(32'h102, 32'h0000_00CD, 32'h1122_3344, 0, 1'b0, 1'b0);
        do_store(32'h103, 32'h0000_00CD, 32'h1122_3344, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_store($urandom, $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_store(32'h0000_0204, 32'h0000_005A, 32'hA5A5_A5A5, 3, 1'b0, 1'b1);
        tick();
        total++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_start_queued: rd=%b busy=%b, want 0 0", mem_rd_en, busy);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; addr = 32'h0000_0208; wdata = 32'h55;
        tick();
        start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1 check_all_zero("reset_async");
        mem_rd_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        reset = 1'b0;
        tick();
        mem_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_all_zero("after_reset_mid");
            tick();
        end
        do_store(32'h0000_0105, 32'h0000_00E7, 32'h0BAD_CAFE, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_store(32'h0000_0400, 32'h0000_0011, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        do_store(32'h0000_0407, 32'h0000_0022, 32'h0000_0000, 0, 1'b0, 1'b0);
    endtask

`ifdef STORE_BYTE_MERGE_HALF_EN
    task automatic test_half();
        do_store(32'h102, 32'h0000_BEEF, 32'h1122_3344, 0, 1'b1, 1'b0);
        do_store(32'h100, 32'h0000_BEEF, 32'h1122_3344, 1, 1'b1, 1'b0);
        start = 1'b1; addr = 32'h101; wdata = 32'hBEEF; half = 1'b1;
        tick();
        start = 1'b0; half = 1'b0;
        total++;
        if (done !== 1'b1 || misalign !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL half_misalign: done=%b misalign=%b rd=%b wr=%b, want 1 1 0 0",
                     done, misalign, mem_rd_en, mem_wr_en);
        end
        tick();
        total++;
        if (done !== 1'b0 || misalign !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL half_misalign_after: done=%b misalign=%b busy=%b rd=%b, want 0 0 0 0",
                     done, misalign, busy, mem_rd_en);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef STORE_BYTE_MERGE_HALF_EN
        test_half();
`endif
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: pending=%0d, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
